// File: rtl/control_fsm.sv
// control_fsm: multi-cycle control sequencer for the datapath.
//   Decodes opcode/fcode into the CTRL_* strobes, stretches loads over
//   LOAD_LAT wait cycles plus one writeback cycle (holding the PC meanwhile),
//   handles program start/finish and keeps saturating benchmark counters.
// Ports:
//   CLK, reset_n          clock, asynchronous active-low reset
//   START                 program start request (level, honoured in IDLE/FIN)
//   opcode, fcode         instruction fields from the datapath
//   IF_DONE               end-of-program flag from fetch
//   DP_INIT               datapath init pulse (one cycle in INIT)
//   CTRL_*                datapath controls (combinational decode)
//   BUSY, PROG_DONE       sequencer status
//   cycle_count           busy cycles (RUN/LD_WAIT/LD_WB)
//   instr_count           retired instructions
module control_fsm #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             START,
    input  logic [3:0]       opcode,
    input  logic             fcode,
    input  logic             IF_DONE,
    output logic             DP_INIT,
    output logic             CTRL_pc_hold,
    output logic             CTRL_branch_rel_nz,
    output logic             CTRL_branch_rel_z,
    output logic             CTRL_branch_abs,
    output logic             CTRL_reg_write_en,
    output logic             CTRL_reg_sel,
    output logic             CTRL_lut_in,
    output logic             CTRL_mem_to_reg,
    output logic             CTRL_alu_src,
    output logic             CTRL_alu_sc_in,
    output logic             CTRL_read_mem,
    output logic             CTRL_write_mem,
    output logic [2:0]       CTRL_alu_op,
    output logic             BUSY,
    output logic             PROG_DONE,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned        WAIT_W    = 2;
    localparam logic [WAIT_W-1:0]  WAIT_INIT = (LOAD_LAT > 0) ? WAIT_W'(LOAD_LAT - 1) : '0;
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_LD_WAIT,
        S_LD_WB,
        S_FIN
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   ins_q, ins_d;
    logic               pc_hold_c;
    logic               count_cycle_c;
    logic               retire_c;

    // State, load-wait and counter registers.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            cyc_q   <= '0;
            ins_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cyc_q   <= cyc_d;
            ins_q   <= ins_d;
        end
    end

    // Next state and decode. Decode is combinational so the strobes line up
    // with the instruction the datapath is presenting this cycle.
    always_comb begin
        state_d            = state_q;
        wait_d             = wait_q;
        cyc_d              = cyc_q;
        ins_d              = ins_q;
        count_cycle_c      = 1'b0;
        retire_c           = 1'b0;
        pc_hold_c          = 1'b0;
        DP_INIT            = 1'b0;
        CTRL_branch_rel_nz = 1'b0;
        CTRL_branch_rel_z  = 1'b0;
        CTRL_branch_abs    = 1'b0;
        CTRL_reg_write_en  = 1'b0;
        CTRL_reg_sel       = 1'b0;
        CTRL_lut_in        = 1'b0;
        CTRL_mem_to_reg    = 1'b0;
        CTRL_alu_src       = 1'b0;
        CTRL_alu_sc_in     = 1'b0;
        CTRL_read_mem      = 1'b0;
        CTRL_write_mem     = 1'b0;
        CTRL_alu_op        = 3'b000;

        case (state_q)
            S_IDLE: begin
                pc_hold_c = 1'b1;
                if (START) state_d = S_INIT;
            end
            S_INIT: begin
                pc_hold_c = 1'b1;
                DP_INIT   = 1'b1;
                cyc_d     = '0;
                ins_d     = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                count_cycle_c = 1'b1;
                if (IF_DONE) begin
                    // End of program wins: the instruction is dropped.
                    state_d = S_FIN;
                end else begin
                    retire_c = (opcode != 4'h8);
                    case (opcode)
                        4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
                            CTRL_alu_op       = opcode[2:0];
                            CTRL_reg_write_en = 1'b1;
                        end
                        4'h5, 4'h6: begin
                            CTRL_alu_op       = opcode[2:0];
                            CTRL_reg_write_en = 1'b1;
                            CTRL_alu_sc_in    = fcode;
                        end
                        4'h7: begin
                            CTRL_alu_src      = 1'b1;
                            CTRL_reg_write_en = 1'b1;
                        end
                        4'h8: begin
                            CTRL_read_mem = 1'b1;
                            pc_hold_c     = 1'b1;
                            wait_d        = WAIT_INIT;
                            state_d       = (LOAD_LAT > 0) ? S_LD_WAIT : S_LD_WB;
                        end
                        4'h9: CTRL_write_mem    = 1'b1;
                        4'hA: CTRL_branch_rel_z = 1'b1;
                        4'hB: CTRL_branch_rel_nz = 1'b1;
                        4'hC: CTRL_branch_abs   = 1'b1;
                        4'hD: begin
                            CTRL_branch_abs = 1'b1;
                            CTRL_lut_in     = 1'b1;
                        end
                        4'hE: begin
                            CTRL_reg_sel      = 1'b1;
                            CTRL_reg_write_en = 1'b1;
                        end
                        default: begin
                            // 0xF: NOP, or HALT when fcode is set.
                            if (fcode) state_d = S_FIN;
                        end
                    endcase
                end
            end
            S_LD_WAIT: begin
                count_cycle_c = 1'b1;
                CTRL_read_mem = 1'b1;
                pc_hold_c     = 1'b1;
                if (wait_q == '0) state_d = S_LD_WB;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            S_LD_WB: begin
                count_cycle_c     = 1'b1;
                retire_c          = 1'b1;
                CTRL_read_mem     = 1'b1;
                CTRL_mem_to_reg   = 1'b1;
                CTRL_reg_write_en = 1'b1;
                state_d           = S_RUN;
            end
            S_FIN: begin
                pc_hold_c = 1'b1;
                if (START) state_d = S_INIT;
            end
            default: state_d = S_IDLE;
        endcase

        // Saturating benchmark counters.
        if (count_cycle_c && (cyc_q != CNT_MAX)) cyc_d = cyc_q + CNT_W'(1);
        if (retire_c && (ins_q != CNT_MAX))      ins_d = ins_q + CNT_W'(1);
    end

    // PC hold is an idle-state default; it must still read 0 while in reset.
    assign CTRL_pc_hold = pc_hold_c & reset_n;
    assign BUSY         = (state_q == S_INIT) || (state_q == S_RUN) ||
                          (state_q == S_LD_WAIT) || (state_q == S_LD_WB);
    assign PROG_DONE    = (state_q == S_FIN);
    assign cycle_count  = cyc_q;
    assign instr_count  = ins_q;

endmodule

// File: tb/tb_control_fsm.sv
// Testbench for control_fsm. Three instances share stimulus:
//   0: CNT_W=16, LOAD_LAT=1   1: CNT_W=16, LOAD_LAT=0   2: CNT_W=4, LOAD_LAT=1
// Control vector bit order:
//   {pc_hold, br_nz, br_z, br_abs, reg_we, reg_sel, lut_in, mem_to_reg,
//    alu_src, alu_sc_in, read_mem, write_mem, alu_op[2:0]}
module tb_control_fsm;

    logic       CLK = 1'b0;
    logic       reset_n;
    logic       START;
    logic [3:0] opcode;
    logic       fcode;
    logic       IF_DONE;

    logic [14:0] ctrl_o [3];
    logic        init_o [3];
    logic        busy_o [3];
    logic        done_o [3];
    logic [15:0] cyc_o  [3];
    logic [15:0] ins_o  [3];

    int vectors     = 0;
    int miscompares = 0;
    int exp_cyc     = 0;
    int exp_ins     = 0;

    localparam logic [14:0] VEC_HOLD = 15'h4000; // pc_hold only
    localparam logic [14:0] VEC_WAIT = 15'h4010; // pc_hold + read_mem
    localparam logic [14:0] VEC_WB   = 15'h0490; // read_mem + mem_to_reg + reg_we

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned CW  = (g == 2) ? 4 : 16;
        localparam int unsigned LAT = (g == 1) ? 0 : 1;
        logic          pc_hold, brnz, brz, babs, rwe, rsel, lut, m2r, src, sc, rd, wr;
        logic [2:0]    alu_op;
        logic [CW-1:0] cyc, ins;

        control_fsm #(.CNT_W(CW), .LOAD_LAT(LAT)) u_dut (
            .CLK                (CLK),
            .reset_n            (reset_n),
            .START              (START),
            .opcode             (opcode),
            .fcode              (fcode),
            .IF_DONE            (IF_DONE),
            .DP_INIT            (init_o[g]),
            .CTRL_pc_hold       (pc_hold),
            .CTRL_branch_rel_nz (brnz),
            .CTRL_branch_rel_z  (brz),
            .CTRL_branch_abs    (babs),
            .CTRL_reg_write_en  (rwe),
            .CTRL_reg_sel       (rsel),
            .CTRL_lut_in        (lut),
            .CTRL_mem_to_reg    (m2r),
            .CTRL_alu_src       (src),
            .CTRL_alu_sc_in     (sc),
            .CTRL_read_mem      (rd),
            .CTRL_write_mem     (wr),
            .CTRL_alu_op        (alu_op),
            .BUSY               (busy_o[g]),
            .PROG_DONE          (done_o[g]),
            .cycle_count        (cyc),
            .instr_count        (ins)
        );

        assign ctrl_o[g] = {pc_hold, brnz, brz, babs, rwe, rsel, lut, m2r,
                            src, sc, rd, wr, alu_op};
        assign cyc_o[g]  = 16'(cyc);
        assign ins_o[g]  = 16'(ins);
    end

    // Reference decode: controls expected in the first RUN cycle of an instruction.
    function automatic logic [14:0] exp_ctrl(input logic [3:0] op, input logic f);
        logic [14:0] v;
        v = '0;
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin v[2:0] = op[2:0]; v[10] = 1'b1; end
            4'h5, 4'h6: begin v[2:0] = op[2:0]; v[10] = 1'b1; v[5] = f; end
            4'h7: begin v[6] = 1'b1; v[10] = 1'b1; end
            4'h8: begin v[14] = 1'b1; v[4] = 1'b1; end
            4'h9: v[3]  = 1'b1;
            4'hA: v[12] = 1'b1;
            4'hB: v[13] = 1'b1;
            4'hC: v[11] = 1'b1;
            4'hD: begin v[11] = 1'b1; v[8] = 1'b1; end
            4'hE: begin v[9] = 1'b1; v[10] = 1'b1; end
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic int sat_inc(input int v, input int maxc);
        return (v >= maxc) ? maxc : v + 1;
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        START   = 1'b0;
        IF_DONE = 1'b0;
        opcode  = 4'hF;
        fcode   = 1'b0;
        reset_n = 1'b0;
        #12;
        @(negedge CLK);
        reset_n = 1'b1;
        tick();
    endtask

    // From IDLE/FIN: request start, check the INIT pulse and cleared counters.
    task automatic start_prog(input int s);
        START = 1'b1;
        tick();
        START = 1'b0;
        @(negedge CLK);
        vectors++;
        if (init_o[s] !== 1'b1 || busy_o[s] !== 1'b1) begin
            miscompares++;
            $display("FAIL init_pulse dut%0d: dp_init=%b busy=%b want 1 1", s, init_o[s], busy_o[s]);
        end
        tick();
        vectors++;
        if (init_o[s] !== 1'b0 || busy_o[s] !== 1'b1 || cyc_o[s] !== 16'd0 || ins_o[s] !== 16'd0) begin
            miscompares++;
            $display("FAIL first_run dut%0d: dp_init=%b busy=%b cyc=%0d ins=%0d want 0 1 0 0",
                     s, init_o[s], busy_o[s], cyc_o[s], ins_o[s]);
        end
        exp_cyc = 0;
        exp_ins = 0;
    endtask

    // Execute one instruction on instance s from a RUN cycle; check every cycle.
    task automatic exec_instr(input int s, input logic [3:0] op, input logic f);
        int lat;
        int maxc;
        lat  = (s == 1) ? 0 : 1;
        maxc = (s == 2) ? 15 : 65535;
        opcode  = op;
        fcode   = f;
        IF_DONE = 1'b0;
        START   = 1'($urandom);
        @(negedge CLK);
        vectors++;
        if (ctrl_o[s] !== exp_ctrl(op, f)) begin
            miscompares++;
            $display("FAIL decode dut%0d op=%h f=%b: got %h want %h", s, op, f, ctrl_o[s], exp_ctrl(op, f));
        end
        exp_cyc = sat_inc(exp_cyc, maxc);
        if (op != 4'h8) exp_ins = sat_inc(exp_ins, maxc);
        tick();
        if (op == 4'h8) begin
            for (int i = 0; i < lat; i++) begin
                @(negedge CLK);
                vectors++;
                if (ctrl_o[s] !== VEC_WAIT || busy_o[s] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ld_wait dut%0d: got %h busy=%b want %h busy=1", s, ctrl_o[s], busy_o[s], VEC_WAIT);
                end
                exp_cyc = sat_inc(exp_cyc, maxc);
                tick();
            end
            @(negedge CLK);
            vectors++;
            if (ctrl_o[s] !== VEC_WB) begin
                miscompares++;
                $display("FAIL ld_wb dut%0d: got %h want %h", s, ctrl_o[s], VEC_WB);
            end
            exp_cyc = sat_inc(exp_cyc, maxc);
            exp_ins = sat_inc(exp_ins, maxc);
            tick();
        end
        vectors++;
        if (cyc_o[s] !== 16'(exp_cyc) || ins_o[s] !== 16'(exp_ins)) begin
            miscompares++;
            $display("FAIL counters dut%0d op=%h: cyc=%0d ins=%0d want %0d %0d",
                     s, op, cyc_o[s], ins_o[s], exp_cyc, exp_ins);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        IF_DONE = 1'b0;
        opcode  = 4'h8;
        fcode   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            START = i[0];
            #7;
            vectors++;
            if ({ctrl_o[0], init_o[0], busy_o[0], done_o[0], cyc_o[0], ins_o[0]} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs: ctrl=%h init=%b busy=%b done=%b cyc=%0d ins=%0d want all 0",
                         ctrl_o[0], init_o[0], busy_o[0], done_o[0], cyc_o[0], ins_o[0]);
            end
        end
        START = 1'b0;
        @(negedge CLK);
        reset_n = 1'b1;
        tick();
        @(negedge CLK);
        vectors++;
        if (ctrl_o[0] !== VEC_HOLD || busy_o[0] !== 1'b0 || done_o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL idle: ctrl=%h busy=%b done=%b want %h 0 0", ctrl_o[0], busy_o[0], done_o[0], VEC_HOLD);
        end
        tick();
        start_prog(0);
    endtask

    task automatic test_decode;
        do_reset();
        start_prog(0);
        for (int op = 0; op <= 14; op++) exec_instr(0, 4'(op), 1'b1);
        exec_instr(0, 4'h5, 1'b0);
        exec_instr(0, 4'h6, 1'b0);
        exec_instr(0, 4'hF, 1'b0);
    endtask

    task automatic test_load_lat1;
        do_reset();
        start_prog(0);
        exec_instr(0, 4'h8, 1'b0);
        vectors++;
        if (cyc_o[0] !== 16'd3 || ins_o[0] !== 16'd1) begin
            miscompares++;
            $display("FAIL load_lat1_counts: cyc=%0d ins=%0d want 3 1", cyc_o[0], ins_o[0]);
        end
    endtask

    task automatic test_load_lat0;
        do_reset();
        start_prog(1);
        exec_instr(1, 4'h8, 1'b1);
        vectors++;
        if (cyc_o[1] !== 16'd2 || ins_o[1] !== 16'd1) begin
            miscompares++;
            $display("FAIL load_lat0_counts: cyc=%0d ins=%0d want 2 1", cyc_o[1], ins_o[1]);
        end
    endtask

    task automatic test_halt_restart;
        do_reset();
        start_prog(0);
        for (int i = 0; i < 5; i++) exec_instr(0, 4'h0, 1'($urandom));
        exec_instr(0, 4'hF, 1'b1);
        START = 1'b0;
        for (int i = 0; i < 3; i++) begin
            opcode = 4'($urandom);
            @(negedge CLK);
            vectors++;
            if (done_o[0] !== 1'b1 || busy_o[0] !== 1'b0 || ctrl_o[0] !== VEC_HOLD ||
                cyc_o[0] !== 16'd6 || ins_o[0] !== 16'd6) begin
                miscompares++;
                $display("FAIL halt_fin: done=%b busy=%b ctrl=%h cyc=%0d ins=%0d want 1 0 %h 6 6",
                         done_o[0], busy_o[0], ctrl_o[0], cyc_o[0], ins_o[0], VEC_HOLD);
            end
            tick();
        end
        start_prog(0);
    endtask

    task automatic test_if_done_load;
        do_reset();
        start_prog(0);
        exec_instr(0, 4'h1, 1'b0);
        START   = 1'b0;
        opcode  = 4'h8;
        IF_DONE = 1'b1;
        @(negedge CLK);
        vectors++;
        if (ctrl_o[0] !== 15'h0) begin
            miscompares++;
            $display("FAIL if_done_ctrl: got %h want 0000", ctrl_o[0]);
        end
        tick();
        IF_DONE = 1'b0;
        vectors++;
        if (done_o[0] !== 1'b1 || cyc_o[0] !== 16'd2 || ins_o[0] !== 16'd1) begin
            miscompares++;
            $display("FAIL if_done_fin: done=%b cyc=%0d ins=%0d want 1 2 1", done_o[0], cyc_o[0], ins_o[0]);
        end
    endtask

    task automatic test_reset_in_load;
        do_reset();
        start_prog(0);
        START  = 1'b0;
        opcode = 4'h8;
        tick();
        @(negedge CLK);
        vectors++;
        if (ctrl_o[0] !== VEC_WAIT) begin
            miscompares++;
            $display("FAIL pre_reset_wait: got %h want %h", ctrl_o[0], VEC_WAIT);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({ctrl_o[0], busy_o[0], done_o[0], cyc_o[0], ins_o[0]} !== '0) begin
            miscompares++;
            $display("FAIL reset_in_load: ctrl=%h busy=%b done=%b cyc=%0d ins=%0d want all 0",
                     ctrl_o[0], busy_o[0], done_o[0], cyc_o[0], ins_o[0]);
        end
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            vectors++;
            if (ctrl_o[0] !== VEC_HOLD || busy_o[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_idle: ctrl=%h busy=%b want %h 0", ctrl_o[0], busy_o[0], VEC_HOLD);
            end
        end
    endtask

    task automatic test_saturate;
        do_reset();
        start_prog(2);
        for (int i = 0; i < 20; i++) exec_instr(2, 4'hF, 1'b0);
        vectors++;
        if (cyc_o[2] !== 16'd15 || ins_o[2] !== 16'd15) begin
            miscompares++;
            $display("FAIL saturate: cyc=%0d ins=%0d want 15 15", cyc_o[2], ins_o[2]);
        end
    endtask

    task automatic test_random;
        for (int s = 0; s < 2; s++) begin
            do_reset();
            start_prog(s);
            for (int n = 0; n < 60; n++) begin
                logic [3:0] op;
                logic       f;
                op = 4'($urandom);
                f  = (op == 4'hF) ? 1'b0 : 1'($urandom);
                exec_instr(s, op, f);
            end
            exec_instr(s, 4'hF, 1'b1);
            vectors++;
            if (done_o[s] !== 1'b1) begin
                miscompares++;
                $display("FAIL random_halt dut%0d: done=%b want 1", s, done_o[s]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        START   = 1'b0;
        IF_DONE = 1'b0;
        opcode  = 4'hF;
        fcode   = 1'b0;
        test_reset();
        test_decode();
        test_load_lat1();
        test_load_lat0();
        test_halt_restart();
        test_if_done_load();
        test_reset_in_load();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
